t03_pc_fetch_ctrl: RTL and testbench

- Program-counter and fetch-sequencing stage that consumes the branch-decision output (b_out) of the branch logic.
- Holds the architectural PC, issues instruction-memory fetch requests with a req/ack handshake, and computes branch/jump targets.
- Redirects the PC when a branch or jump is taken and flushes the wrong-path instruction.
- Sits between the execute-stage branch decision and the instruction-memory/decode interface.

---
 rtl/t03_pkg.sv | 22 ++
 rtl/t03_target_gen.sv | 22 ++
 rtl/t03_pc_fetch_ctrl.sv | 128 ++++++++++++
 tb/tb_t03_pc_fetch_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/t03_pkg.sv
// Shared fetch-stage types and constants for the t03 pipeline slice.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package t03_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DELIVER = 2'd2
    } fetch_state_t;

    // Branch comparison kinds, funct3-encoded so the branch logic can decode directly.
    localparam logic [2:0] BR_EQ  = 3'd0;
    localparam logic [2:0] BR_NE  = 3'd1;
    localparam logic [2:0] BR_LT  = 3'd4;
    localparam logic [2:0] BR_GE  = 3'd5;
    localparam logic [2:0] BR_LTU = 3'd6;
    localparam logic [2:0] BR_GEU = 3'd7;

endpackage

// File: rtl/t03_target_gen.sv
// Branch/jump target compute with low-bit clearing and misalignment detection.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module t03_target_gen #(
    parameter int ADDR_W = 32
) (
    input  logic              is_jalr,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic [ADDR_W-1:0] ex_imm,
    input  logic [ADDR_W-1:0] ex_rs1,
    output logic [ADDR_W-1:0] target,
    output logic              misalign
);

    logic [ADDR_W-1:0] raw;

    assign raw      = (is_jalr ? ex_rs1 : ex_pc) + ex_imm;
    assign misalign = raw[1];
    // bit0 is always dropped; bit1 is dropped too so a misaligned target lands on a word.
    assign target   = {raw[ADDR_W-1:2], 2'b00};

endmodule

// File: rtl/t03_pc_fetch_ctrl.sv
// PC holder and fetch sequencer: req/ack fetch, branch/jump redirect with flush.
// Latency: 2 cycles REQ entry to instr_valid on 0-wait ack; redirect to new request 1 cycle.
// Backpressure: stall freezes pc and blocks new requests; an in-flight request always completes.
module t03_pc_fetch_ctrl
    import t03_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              b_out,
    input  logic              ex_valid,
    input  logic              is_jalr,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic [ADDR_W-1:0] ex_imm,
    input  logic [ADDR_W-1:0] ex_rs1,
    input  logic              stall,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic              flush,
    output logic              misalign_err
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;
    logic              pend_valid_q, pend_valid_d;
    logic              pend_mis_q, pend_mis_d;
    logic [31:0]       instr_q;
    logic [ADDR_W-1:0] tgt;
    logic              tgt_mis;
    logic              redirect;

    t03_target_gen #(.ADDR_W(ADDR_W)) u_target_gen (
        .is_jalr  (is_jalr),
        .ex_pc    (ex_pc),
        .ex_imm   (ex_imm),
        .ex_rs1   (ex_rs1),
        .target   (tgt),
        .misalign (tgt_mis)
    );

    assign redirect = ex_valid & b_out;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        pend_valid_d  = pend_valid_q;
        pend_mis_d    = pend_mis_q;
        imem_req      = 1'b0;
        instr_valid   = 1'b0;
        flush         = 1'b0;
        misalign_err  = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    pc_d         = tgt;
                    flush        = 1'b1;
                    misalign_err = tgt_mis;
                end
                if (!stall) state_d = REQ;
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (pend_valid_q || redirect) begin
                        // Returned word is wrong-path: drop it and refetch at the (oldest) target.
                        pc_d         = pend_valid_q ? pend_target_q : tgt;
                        misalign_err = pend_valid_q ? pend_mis_q : tgt_mis;
                        flush        = 1'b1;
                        pend_valid_d = 1'b0;
                        state_d      = REQ;
                    end else begin
                        state_d = DELIVER;
                    end
                end else if (redirect && !pend_valid_q) begin
                    pend_target_d = tgt;
                    pend_mis_d    = tgt_mis;
                    pend_valid_d  = 1'b1;
                end
            end
            DELIVER: begin
                if (redirect) begin
                    pc_d         = tgt;
                    flush        = 1'b1;
                    misalign_err = tgt_mis;
                end else begin
                    instr_valid = 1'b1;
                    pc_d        = pc_q + ADDR_W'(4);
                end
                state_d = stall ? IDLE : REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            pend_target_q <= '0;
            pend_valid_q  <= 1'b0;
            pend_mis_q    <= 1'b0;
            instr_q       <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
            pend_valid_q  <= pend_valid_d;
            pend_mis_q    <= pend_mis_d;
            if (state_q == REQ && imem_ack) instr_q <= imem_rdata;
        end
    end

    assign pc        = pc_q;
    assign pc_plus4  = pc_q + ADDR_W'(4);
    assign imem_addr = pc_q;
    assign instr     = instr_q;

endmodule

// File: tb/tb_t03_pc_fetch_ctrl.sv
// Directed vector bench for t03_pc_fetch_ctrl: table of per-cycle stimulus and expectations
// plus short hand-written sequences for wait-state redirect, stall and reset corners.
module tb_t03_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst, b_out, ex_valid, is_jalr, stall, imem_ack;
    logic [31:0] ex_pc, ex_imm, ex_rs1, imem_rdata;
    logic        imem_req, instr_valid, flush, misalign_err;
    logic [31:0] imem_addr, pc, pc_plus4, instr;

    always #5 clk = ~clk;

    t03_pc_fetch_ctrl #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .b_out        (b_out),
        .ex_valid     (ex_valid),
        .is_jalr      (is_jalr),
        .ex_pc        (ex_pc),
        .ex_imm       (ex_imm),
        .ex_rs1       (ex_rs1),
        .stall        (stall),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .flush        (flush),
        .misalign_err (misalign_err)
    );

    typedef struct {
        logic        rst, stall, ack;
        logic [31:0] rdata;
        logic        exv, bo, jalr;
        logic [31:0] expc, imm, rs1;
        logic        e_req;
        logic [31:0] e_pc;
        logic        e_vld;
        logic [31:0] e_instr;
        logic        e_flush, e_mis;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   nflush;
    vec_t tbl[27];

    function automatic vec_t mk(input logic r, input logic st, input logic ak, input logic [31:0] rd,
                                input logic xv, input logic bo, input logic jr,
                                input logic [31:0] xp, input logic [31:0] im, input logic [31:0] r1,
                                input logic ereq, input logic [31:0] epc, input logic evld,
                                input logic [31:0] einstr, input logic efl, input logic emis);
        vec_t v;
        v.rst = r; v.stall = st; v.ack = ak; v.rdata = rd;
        v.exv = xv; v.bo = bo; v.jalr = jr; v.expc = xp; v.imm = im; v.rs1 = r1;
        v.e_req = ereq; v.e_pc = epc; v.e_vld = evld; v.e_instr = einstr;
        v.e_flush = efl; v.e_mis = emis;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, sample outputs 2ns later.
    task automatic run(input vec_t v, input string nm);
        @(negedge clk);
        rst = v.rst; stall = v.stall; imem_ack = v.ack; imem_rdata = v.rdata;
        ex_valid = v.exv; b_out = v.bo; is_jalr = v.jalr;
        ex_pc = v.expc; ex_imm = v.imm; ex_rs1 = v.rs1;
        #2;
        chk({nm, "_req"}, imem_req, v.e_req);
        if (v.e_req) chk({nm, "_addr"}, imem_addr, v.e_pc);
        chk({nm, "_pc"}, pc, v.e_pc);
        chk({nm, "_pc4"}, pc_plus4, v.e_pc + 32'd4);
        chk({nm, "_vld"}, instr_valid, v.e_vld);
        if (v.e_vld) chk({nm, "_instr"}, instr, v.e_instr);
        chk({nm, "_flush"}, flush, v.e_flush);
        chk({nm, "_mis"}, misalign_err, v.e_mis);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1; stall = 1'b0; imem_ack = 1'b0; ex_valid = 1'b0; b_out = 1'b0; is_jalr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; b_out = 1'b0; ex_valid = 1'b0; is_jalr = 1'b0; stall = 1'b0; imem_ack = 1'b0;
        ex_pc = '0; ex_imm = '0; ex_rs1 = '0; imem_rdata = '0;

        // Free-run fetch, branch redirect, JALR targets, same-cycle redirect+ack, pc wrap.
        tbl[0]  = mk(1,0,0,32'h0,         0,0,0,32'h0,32'h0,32'h0,        0,32'h0,0,32'h0,0,0);
        tbl[1]  = mk(0,0,0,32'h0,         0,0,0,32'h0,32'h0,32'h0,        0,32'h0,0,32'h0,0,0);
        tbl[2]  = mk(0,0,1,32'h11110000,  0,0,0,32'h0,32'h0,32'h0,        1,32'h0,0,32'h0,0,0);
        tbl[3]  = mk(0,0,0,32'h0,         0,0,0,32'h0,32'h0,32'h0,        0,32'h0,1,32'h11110000,0,0);
        tbl[4]  = mk(0,0,1,32'h11110004,  0,0,0,32'h0,32'h0,32'h0,        1,32'h4,0,32'h0,0,0);
        tbl[5]  = mk(0,0,0,32'h0,         0,0,0,32'h0,32'h0,32'h0,        0,32'h4,1,32'h11110004,0,0);
        tbl[6]  = mk(0,0,1,32'h11110008,  0,0,0,32'h0,32'h0,32'h0,        1,32'h8,0,32'h0,0,0);
        tbl[7]  = mk(0,0,0,32'h0,         0,0,0,32'h0,32'h0,32'h0,        0,32'h8,1,32'h11110008,0,0);
        tbl[8]  = mk(0,0,1,32'h1111000C,  0,0,0,32'h0,32'h0,32'h0,        1,32'hC,0,32'h0,0,0);
        tbl[9]  = mk(0,0,0,32'h0,         0,0,0,32'h0,32'h0,32'h0,        0,32'hC,1,32'h1111000C,0,0);
        tbl[10] = mk(0,0,1,32'h22220010,  0,0,0,32'h0,32'h0,32'h0,        1,32'h10,0,32'h0,0,0);
        tbl[11] = mk(0,0,0,32'h0,         1,1,0,32'h10,32'hFFFFFFF8,32'h0, 0,32'h10,0,32'h0,1,0);
        tbl[12] = mk(0,0,0,32'h0,         0,0,0,32'h0,32'h0,32'h0,        1,32'h8,0,32'h0,0,0);
        tbl[13] = mk(0,0,1,32'h33330008,  0,0,0,32'h0,32'h0,32'h0,        1,32'h8,0,32'h0,0,0);
        tbl[14] = mk(0,0,0,32'h0,         0,0,0,32'h0,32'h0,32'h0,        0,32'h8,1,32'h33330008,0,0);
        tbl[15] = mk(0,0,1,32'h4444000C,  0,0,0,32'h0,32'h0,32'h0,        1,32'hC,0,32'h0,0,0);
        tbl[16] = mk(0,0,0,32'h0,         1,1,1,32'h0,32'h4,32'h101,      0,32'hC,0,32'h0,1,0);
        tbl[17] = mk(0,0,1,32'h55550104,  0,0,0,32'h0,32'h0,32'h0,        1,32'h104,0,32'h0,0,0);
        tbl[18] = mk(0,0,0,32'h0,         1,1,1,32'h0,32'h0,32'h102,      0,32'h104,0,32'h0,1,1);
        tbl[19] = mk(0,0,0,32'h0,         0,0,0,32'h0,32'h0,32'h0,        1,32'h100,0,32'h0,0,0);
        tbl[20] = mk(0,0,1,32'h66660100,  0,0,0,32'h0,32'h0,32'h0,        1,32'h100,0,32'h0,0,0);
        tbl[21] = mk(0,0,0,32'h0,         0,0,0,32'h0,32'h0,32'h0,        0,32'h100,1,32'h66660100,0,0);
        tbl[22] = mk(0,0,1,32'h99999999,  1,1,0,32'h200,32'hFFFFFDFC,32'h0, 1,32'h104,0,32'h0,1,0);
        tbl[23] = mk(0,0,0,32'h0,         0,0,0,32'h0,32'h0,32'h0,        1,32'hFFFFFFFC,0,32'h0,0,0);
        tbl[24] = mk(0,0,1,32'h7777FFFC,  0,0,0,32'h0,32'h0,32'h0,        1,32'hFFFFFFFC,0,32'h0,0,0);
        tbl[25] = mk(0,0,0,32'h0,         0,1,0,32'h0,32'h40,32'h0,       0,32'hFFFFFFFC,1,32'h7777FFFC,0,0);
        tbl[26] = mk(0,0,0,32'h0,         0,0,0,32'h0,32'h0,32'h0,        1,32'h0,0,32'h0,0,0);

        repeat (2) @(negedge clk);
        for (int i = 0; i < 27; i++) run(tbl[i], $sformatf("r%0d", i));

        // Redirect during a 3-cycle ack wait, then a misaligned pending JALR.
        reset_dut();
        run(mk(0,0,0,32'h0, 0,0,0,32'h0,32'h0,32'h0, 0,32'h0,0,32'h0,0,0), "w_idle");
        nflush = 0;
        run(mk(0,0,0,32'h0, 1,1,0,32'h80,32'h20,32'h0, 1,32'h0,0,32'h0,0,0), "wA"); nflush += int'(flush);
        run(mk(0,0,0,32'h0, 0,0,0,32'h0,32'h0,32'h0, 1,32'h0,0,32'h0,0,0), "wB");     nflush += int'(flush);
        run(mk(0,0,0,32'h0, 0,0,0,32'h0,32'h0,32'h0, 1,32'h0,0,32'h0,0,0), "wC");     nflush += int'(flush);
        run(mk(0,0,1,32'hDEAD0000, 0,0,0,32'h0,32'h0,32'h0, 1,32'h0,0,32'h0,1,0), "wD"); nflush += int'(flush);
        run(mk(0,0,1,32'hBEEF00A0, 0,0,0,32'h0,32'h0,32'h0, 1,32'hA0,0,32'h0,0,0), "wE"); nflush += int'(flush);
        chk("w_one_flush", nflush, 32'd1);
        run(mk(0,0,0,32'h0, 0,0,0,32'h0,32'h0,32'h0, 0,32'hA0,1,32'hBEEF00A0,0,0), "wF");
        run(mk(0,0,0,32'h0, 1,1,1,32'h0,32'h0,32'h302, 1,32'hA4,0,32'h0,0,0), "wG");
        run(mk(0,0,1,32'h12345678, 0,0,0,32'h0,32'h0,32'h0, 1,32'hA4,0,32'h0,1,1), "wH");
        run(mk(0,0,0,32'h0, 0,0,0,32'h0,32'h0,32'h0, 1,32'h300,0,32'h0,0,0), "wI");

        // Stall in IDLE with a redirect captured mid-stall.
        reset_dut();
        run(mk(0,1,0,32'h0, 0,0,0,32'h0,32'h0,32'h0, 0,32'h0,0,32'h0,0,0), "s1");
        run(mk(0,1,0,32'h0, 0,0,0,32'h0,32'h0,32'h0, 0,32'h0,0,32'h0,0,0), "s2");
        run(mk(0,1,0,32'h0, 1,1,0,32'h400,32'h10,32'h0, 0,32'h0,0,32'h0,1,0), "s3");
        run(mk(0,1,0,32'h0, 0,0,0,32'h0,32'h0,32'h0, 0,32'h410,0,32'h0,0,0), "s4");
        run(mk(0,0,0,32'h0, 0,0,0,32'h0,32'h0,32'h0, 0,32'h410,0,32'h0,0,0), "s5");
        run(mk(0,0,0,32'h0, 0,0,0,32'h0,32'h0,32'h0, 1,32'h410,0,32'h0,0,0), "s6");

        // Reset while in REQ, followed by a stray ack.
        run(mk(1,0,0,32'h0, 0,0,0,32'h0,32'h0,32'h0, 1,32'h410,0,32'h0,0,0), "x1");
        run(mk(0,0,1,32'hBAD0BAD0, 0,0,0,32'h0,32'h0,32'h0, 0,32'h0,0,32'h0,0,0), "x2");
        run(mk(0,0,0,32'h0, 0,0,0,32'h0,32'h0,32'h0, 1,32'h0,0,32'h0,0,0), "x3");
        chk("x_instr_clear", instr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
